// File: rtl/uart_rx_if.sv
// Serial-in / parallel-out signal bundle for uart_rx.
// slave: receiver side; master: the line driver and byte consumer.
interface uart_rx_if #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned PRESCALE_W = 6
) ();
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATAWIDTH-1:0]  P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  BUSY;

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
  );

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with 3-sample majority vote per bit.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on RX_IN.
module uart_rx #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave rx_bus
);
  localparam int unsigned BitCntW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] One = PRESCALE_W'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [1:0]            samp_q, samp_d;
  logic                  bit_q, bit_d;
  logic [DATAWIDTH-1:0]  shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic [DATAWIDTH-1:0]  p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic                  rx;
  logic [PRESCALE_W-1:0] half;
  logic                  last_edge;
  logic                  maj;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_bus.RX_IN};
  end

  assign rx = sync_q[1];
`else
  assign rx = rx_bus.RX_IN;
`endif

  assign half      = {1'b0, psc_q[PRESCALE_W-1:1]};
  assign last_edge = (edge_cnt_q == psc_q - One);
  // Third sample is taken live, so the vote is usable in the H+1 cycle itself.
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    psc_d      = psc_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != StIdle) begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + One;
      if (edge_cnt_q == half - One) samp_d[0] = rx;
      if (edge_cnt_q == half)       samp_d[1] = rx;
      if (edge_cnt_q == half + One) bit_d     = maj;
    end

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx) begin
          state_d   = StStart;
          psc_d     = rx_bus.PRESCALE;
          par_en_d  = rx_bus.PAR_EN;
          par_typ_d = rx_bus.PAR_TYP;
          par_err_d = 1'b0;
        end
      end
      StStart: begin
        if (last_edge) state_d = bit_q ? StIdle : StData;
      end
      StData: begin
        if (last_edge) begin
          shift_d   = {bit_q, shift_q[DATAWIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntW'(DATAWIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (last_edge) begin
          par_err_d = (bit_q != (^shift_q ^ par_typ_q));
          state_d   = StStop;
        end
      end
      StStop: begin
        // Decide early so a start bit directly after the stop bit is caught.
        if (edge_cnt_q == half + One) begin
          se_d       = ~maj;
          pe_d       = par_err_q;
          if (maj && !par_err_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
          edge_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      psc_q      <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_q     <= '0;
      bit_q      <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      psc_q      <= psc_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign rx_bus.P_DATA     = p_data_q;
  assign rx_bus.DATA_VALID = dv_q;
  assign rx_bus.PAR_ERR    = pe_q;
  assign rx_bus.STP_ERR    = se_q;
  assign rx_bus.BUSY       = (state_q != StIdle);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART_TX. Same frame format: start bit 0, DATAWIDTH data bits LSB first, optional parity bit, stop bit 1.
- Oversamples RX_IN at PRESCALE clocks per bit and recovers each bit by 3-sample majority vote.
- Presents the parallel byte with a one-cycle DATA_VALID pulse. Flags parity and stop errors.
- Sits between the serial pin and the system register/FIFO path in the UART pair.

Parameters:
- DATAWIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of PRESCALE input and of the edge counter.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line, idle high.
- PRESCALE  input  PRESCALE_W  clocks per bit. Legal values are even and in 8..2^PRESCALE_W-2.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATAWIDTH  received data, held until the next valid frame.
- DATA_VALID  output  1  one-cycle pulse: frame received with no error.
- PAR_ERR  output  1  one-cycle pulse: parity mismatch.
- STP_ERR  output  1  one-cycle pulse: stop bit sampled 0.
- BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, counters=0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, BUSY=0.
- PRESCALE, PAR_EN and PAR_TYP are latched on IDLE->START. Changes mid-frame are ignored.
- Edge counter: counts 0..PRESCALE-1 within each bit and wraps to 0 at PRESCALE-1. Bit counter advances on each wrap.
- Sampling: RX_IN is sampled at edge counts H-1, H and H+1, where H=PRESCALE/2. The bit value is the majority of the three samples and is valid from edge H+2.
- States:
  - IDLE: RX_IN==0 moves to START with edge counter=0. Otherwise stay.
  - START: at end of bit, a majority of 0 moves to DATA. A majority of 1 is a glitch: go to IDLE with no output pulse.
  - DATA: shift the majority value into the shift register, LSB first. After DATAWIDTH bits go to PARITY if PAR_EN, else to STOP.
  - PARITY: expected bit = XOR of data bits, XOR PAR_TYP. A mismatch sets an internal error flag. Go to STOP.
  - STOP: the decision is made at edge H+2, not at end of bit, so back-to-back frames are not missed.
    - Stop majority 0: pulse STP_ERR.
    - Parity flag set: pulse PAR_ERR.
    - No error: load P_DATA and pulse DATA_VALID.
    - All pulses occur in the same cycle. Then go to IDLE.
- On any error, P_DATA keeps its previous value.
- After a stop error, IDLE re-arms immediately. If RX_IN is still low, a new START begins; a break condition therefore yields repeated STP_ERR.
- Latency: DATA_VALID rises at CLK edge (1 + DATAWIDTH + PAR_EN)*PRESCALE + H+2 after the first cycle RX_IN is seen low.
- Reset asserted mid-frame aborts the frame with no pulses. After release, reception resumes at the next low level on RX_IN.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset value 1, before the FSM. All latencies grow by 2 CLK cycles.
- Undefined: RX_IN feeds the FSM directly and the source must already be synchronous to CLK.

Test Plan:
- PRESCALE=8, PAR_EN=0, send 0xA5 -> one DATA_VALID pulse, P_DATA=0xA5, no error pulses, BUSY high for 10*8-(8-6) cycles.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> DATA_VALID, P_DATA=0x3C. Repeat with parity bit 1 -> PAR_ERR pulse only, P_DATA stays 0x3C.
- PRESCALE=8, 0x55 with stop bit forced 0 -> STP_ERR pulse, no DATA_VALID, next frame 0x12 received correctly.
- RX_IN low for 3 clocks in IDLE, PRESCALE=8 -> returns to IDLE, no pulses, BUSY low again after 8 clocks.
- One-clock 0 glitch at edge H of data bit 3 of 0xFF -> majority vote still gives P_DATA=0xFF, DATA_VALID.
- Assert RST at data bit 4 of a frame, then send 0x81 -> no pulses for the aborted frame, DATA_VALID with P_DATA=0x81. Verify once with UART_RX_SYNC_EN defined and once without.
